remote_bus_arbiter: RTL and testbench
=====================================

// Module: remote_bus_arbiter
// PURPOSE
//  Shares one global-memory port between NUM_CORES PASC cores' remote buses
//  (remote_wren/rden/addr/write_val/read_val/ready). Round-robin, one
//  transaction in flight. Sits between the core array and the shared memory.
// PARAMETERS
//  NUM_CORES  4  number of requesting cores (2..16)
// PORTS
//  clk             in   1          system clock; all state on rising edge
//  reset           in   1          asynchronous, active-high reset
//  core_wren       in   NUM_CORES  per-core write request
//  core_rden       in   NUM_CORES  per-core read request
//  core_addr       in   16*N       per-core address, core i at [16i+15:16i]
//  core_write_val  in   16*N       per-core write data, same packing
//  core_ready      out  NUM_CORES  one-cycle completion pulse to granted core
//  core_read_val   out  16         read data broadcast; valid with core_ready
//  mem_req         out  1          transaction request to shared memory
//  mem_wren        out  1          1=write, 0=read; valid while mem_req
//  mem_addr        out  16         latched address
//  mem_write_val   out  16         latched write data
//  mem_read_val    in   16         memory read data, sampled on mem_ack
//  mem_ack         in   1          memory completes current mem_req this cycle
//  stall_count     out  32         see CONFIGURATION
// BEHAVIOUR
//  - Reset: state=IDLE, core_ready=0, core_read_val=0, mem_req=0, mem_wren=0,
//    mem_addr=0, mem_write_val=0, last_grant=NUM_CORES-1, stall_count=0.
//  - Request of core i = core_wren[i] | core_rden[i]; wren wins if both set.
//  - IDLE: if any request, pick first requester scanning last_grant+1 upward
//    (mod NUM_CORES); latch its addr/data/op into mem_* regs, grant<=i,
//    last_grant<=i, mem_req<=1, go BUSY. No request: stay IDLE.
//  - BUSY: mem_req and mem_* held stable. On mem_ack: mem_req<=0,
//    core_read_val<=mem_read_val (reads only; writes leave it unchanged),
//    go DONE.
//  - DONE: core_ready[grant]=1 (registered, exactly one cycle); go IDLE.
//    Core drops/changes request at the edge ending DONE; no re-grant of a
//    stale request.
//  - Latency, zero-wait memory: request seen cycle 0, mem_req cycle 1, ready
//    cycle 2. Each extra cycle of mem_ack delay adds one cycle.
//  - Requester deasserting while granted: transaction still completes; ready
//    still pulsed. Inputs of non-granted cores ignored.
//  - mem_ack outside BUSY ignored. core_ready never has more than one bit set.
//  - Reset mid-transaction: immediate return to reset values; in-flight
//    transaction abandoned; first post-reset grant goes to lowest requester.
// CONFIGURATION
//  REMOTE_ARB_STATS_EN defined: stall_count increments each cycle in which at
//    least one core requests but is not the current grant; saturates at
//    32'hFFFF_FFFF; cleared only by reset.
//  Undefined: no counter logic; stall_count tied to 0.
// STRUCTURE
//  - remote_bus_defs.vh: REMOTE_ADDR_WIDTH=16, REMOTE_DATA_WIDTH=16, state
//    encodings ARB_IDLE/ARB_BUSY/ARB_DONE.
//  - Sub-module rr_priority_picker: combinational, request vector + last_grant
//    -> one-hot grant + index. Top keeps FSM, latches, counter.
// TESTING
//  1. Core 0 read 0x0100, mem_ack same cycle as mem_req, mem_read_val=0x1234
//     -> mem_req cycle 1, core_ready=4'b0001 cycle 2, core_read_val=0x1234.
//  2. Cores 0,1,2 write 0xA0/0xA1/0xA2 together from reset -> mem_addr order
//     0xA0,0xA1,0xA2; each core_ready once, in that order.
//  3. Cores 1,3 request continuously for 8 transactions -> grants alternate
//     1,3,1,3...; neither waits more than one other transaction.
//  4. mem_ack delayed 4 cycles -> mem_addr/mem_wren stable whole BUSY;
//     core_ready at cycle 6; no other core_ready bit set.
//  5. reset asserted during BUSY -> mem_req=0 same cycle; after release,
//     cores 2,3 request -> core 2 granted first.
//  6. STATS_EN, cores 0,1 both request one zero-wait transaction each ->
//     stall_count=3; without macro stays 0.

Source files
------------

// File: rtl/remote_bus_arbiter_pkg.sv
// Shared widths, FSM state encoding and the saturating-increment helper for
// the remote bus arbiter.
package remote_bus_arbiter_pkg;

    localparam int REMOTE_ADDR_WIDTH = 16;
    localparam int REMOTE_DATA_WIDTH = 16;
    localparam int STAT_WIDTH        = 32;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/remote_bus_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: chooses the first requester strictly after
// last_grant (wrapping) and reports it as one-hot plus index.
module rr_priority_picker
    import remote_bus_arbiter_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     last_grant,
    output logic [NUM_CORES-1:0] grant_onehot,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 valid
);

    // Scan last_grant+1 .. last_grant+NUM_CORES; only the first hit is kept.
    always_comb begin
        int         raw;
        logic [IDX_W-1:0] cand;
        logic       found;
        logic       hit;
        grant_onehot = {NUM_CORES{1'b0}};
        grant_idx    = {IDX_W{1'b0}};
        found        = 1'b0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            raw   = int'(last_grant) + k;
            cand  = IDX_W'((raw >= NUM_CORES) ? raw - NUM_CORES : raw);
            hit   = ~found & req[cand];
            found = found | hit;
            grant_onehot[cand] = grant_onehot[cand] | hit;
            grant_idx = hit ? cand : grant_idx;
        end
    end

    assign valid = |req;

endmodule

// File: rtl/remote_bus_arbiter.sv
// Round-robin arbiter sharing one global-memory port among NUM_CORES remote
// buses, one transaction in flight. Define REMOTE_ARB_STATS_EN for stall_count.
module remote_bus_arbiter
    import remote_bus_arbiter_pkg::*;
#(
    parameter int NUM_CORES = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_CORES-1:0]                   core_wren,
    input  logic [NUM_CORES-1:0]                   core_rden,
    input  logic [REMOTE_ADDR_WIDTH*NUM_CORES-1:0] core_addr,
    input  logic [REMOTE_DATA_WIDTH*NUM_CORES-1:0] core_write_val,
    output logic [NUM_CORES-1:0]                   core_ready,
    output logic [REMOTE_DATA_WIDTH-1:0]           core_read_val,
    output logic                                   mem_req,
    output logic                                   mem_wren,
    output logic [REMOTE_ADDR_WIDTH-1:0]           mem_addr,
    output logic [REMOTE_DATA_WIDTH-1:0]           mem_write_val,
    input  logic [REMOTE_DATA_WIDTH-1:0]           mem_read_val,
    input  logic                                   mem_ack,
    output logic [STAT_WIDTH-1:0]                  stall_count
);

    localparam int IDX_W = $clog2(NUM_CORES);

    arb_state_t                   state_r, state_next_s;
    logic [NUM_CORES-1:0]         req_s, pick_onehot_s, grant_onehot_r;
    logic [IDX_W-1:0]             pick_idx_s, last_grant_r;
    logic                         pick_valid_s, sel_wren_s;
    logic [REMOTE_ADDR_WIDTH-1:0] sel_addr_s;
    logic [REMOTE_DATA_WIDTH-1:0] sel_data_s;

    assign req_s = core_wren | core_rden;

    rr_priority_picker #(.NUM_CORES(NUM_CORES), .IDX_W(IDX_W)) u_picker (
        .req          (req_s),
        .last_grant   (last_grant_r),
        .grant_onehot (pick_onehot_s),
        .grant_idx    (pick_idx_s),
        .valid        (pick_valid_s)
    );

    // AND-OR mux of the picked core's fields; write wins when both bits are set.
    always_comb begin
        sel_addr_s = {REMOTE_ADDR_WIDTH{1'b0}};
        sel_data_s = {REMOTE_DATA_WIDTH{1'b0}};
        sel_wren_s = |(core_wren & pick_onehot_s);
        for (int i = 0; i < NUM_CORES; i++) begin
            sel_addr_s = sel_addr_s | (core_addr[i*REMOTE_ADDR_WIDTH +: REMOTE_ADDR_WIDTH]
                                       & {REMOTE_ADDR_WIDTH{pick_onehot_s[i]}});
            sel_data_s = sel_data_s | (core_write_val[i*REMOTE_DATA_WIDTH +: REMOTE_DATA_WIDTH]
                                       & {REMOTE_DATA_WIDTH{pick_onehot_s[i]}});
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= ARB_IDLE;
        else       state_r <= state_next_s;
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (pick_valid_s) state_next_s = ARB_BUSY;
                else              state_next_s = ARB_IDLE;
            end
            ARB_BUSY: begin
                if (mem_ack) state_next_s = ARB_DONE;
                else         state_next_s = ARB_BUSY;
            end
            ARB_DONE: state_next_s = ARB_IDLE;
            default:  state_next_s = ARB_IDLE;
        endcase
    end

    // Grant latch, memory-side registers and the one-cycle ready pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_ready     <= {NUM_CORES{1'b0}};
            core_read_val  <= {REMOTE_DATA_WIDTH{1'b0}};
            mem_req        <= 1'b0;
            mem_wren       <= 1'b0;
            mem_addr       <= {REMOTE_ADDR_WIDTH{1'b0}};
            mem_write_val  <= {REMOTE_DATA_WIDTH{1'b0}};
            grant_onehot_r <= {NUM_CORES{1'b0}};
            last_grant_r   <= IDX_W'(NUM_CORES - 1);
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    core_ready <= {NUM_CORES{1'b0}};
                    if (pick_valid_s) begin
                        mem_req        <= 1'b1;
                        mem_wren       <= sel_wren_s;
                        mem_addr       <= sel_addr_s;
                        mem_write_val  <= sel_data_s;
                        grant_onehot_r <= pick_onehot_s;
                        last_grant_r   <= pick_idx_s;
                    end
                end
                ARB_BUSY: begin
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        core_ready <= grant_onehot_r;
                        if (!mem_wren) core_read_val <= mem_read_val;
                    end
                end
                ARB_DONE: core_ready <= {NUM_CORES{1'b0}};
                default: begin
                    core_ready <= {NUM_CORES{1'b0}};
                    mem_req    <= 1'b0;
                end
            endcase
        end
    end

`ifdef REMOTE_ARB_STATS_EN
    logic [NUM_CORES-1:0]  eff_grant_s;
    logic                  stall_s;
    logic [STAT_WIDTH-1:0] stall_count_r;

    // While IDLE the picker's winner counts as granted, so only losers stall.
    always_comb begin
        eff_grant_s = (state_r == ARB_IDLE) ? pick_onehot_s : grant_onehot_r;
        stall_s     = |(req_s & ~eff_grant_s);
    end

    // Saturating stall counter, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        stall_count_r <= 32'd0;
        else if (stall_s) stall_count_r <= sat_inc(stall_count_r);
    end

    assign stall_count = stall_count_r;
`else
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_remote_bus_arbiter.sv
// Scoreboard bench for remote_bus_arbiter: stimulus pushes expected memory
// requests and ready responses; a negedge monitor pops and compares.
module tb_remote_bus_arbiter;

    localparam int N = 4;
`ifdef REMOTE_ARB_STATS_EN
    localparam int EXP_STALL = 3;
`else
    localparam int EXP_STALL = 0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    core_wren, core_rden, core_ready;
    logic [16*N-1:0] core_addr, core_write_val;
    logic [15:0]     core_read_val, mem_addr, mem_write_val, mem_read_val;
    logic            mem_req, mem_wren, mem_ack;
    logic [31:0]     stall_count;

    always #5 clk = ~clk;

    remote_bus_arbiter #(.NUM_CORES(N)) dut (
        .clk(clk), .reset(reset),
        .core_wren(core_wren), .core_rden(core_rden),
        .core_addr(core_addr), .core_write_val(core_write_val),
        .core_ready(core_ready), .core_read_val(core_read_val),
        .mem_req(mem_req), .mem_wren(mem_wren), .mem_addr(mem_addr),
        .mem_write_val(mem_write_val), .mem_read_val(mem_read_val),
        .mem_ack(mem_ack), .stall_count(stall_count)
    );

    typedef struct { logic [15:0] addr; logic wren; logic [15:0] wdata; } mem_exp_t;
    typedef struct { logic [N-1:0] ready; logic [15:0] rval; } rdy_exp_t;
    mem_exp_t exp_mem[$];
    rdy_exp_t exp_rdy[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: acks after ack_delay cycles of mem_req; read data = addr + 0x1134.
    int   ack_delay = 0;
    int   wait_cnt  = 0;
    logic spurious  = 1'b0;
    always @(negedge clk) begin
        if (mem_req) begin
            mem_ack  = (wait_cnt >= ack_delay);
            wait_cnt = wait_cnt + 1;
        end else begin
            wait_cnt = 0;
            mem_ack  = spurious;
        end
        mem_read_val = mem_addr + 16'h1134;
    end

    // Monitor: compares new mem requests, BUSY stability and ready pulses.
    logic        prev_req = 1'b0;
    logic [15:0] held_addr;
    logic        held_wren;
    always @(negedge clk) begin : monitor
        mem_exp_t e;
        rdy_exp_t r;
        if (mem_req && !prev_req) begin
            if (exp_mem.size() == 0) begin
                check("unexpected_mem_req", {16'h0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
                e = exp_mem.pop_front();
                check("mem_addr", {16'h0, mem_addr}, {16'h0, e.addr});
                check("mem_wren", {31'h0, mem_wren}, {31'h0, e.wren});
                if (e.wren) check("mem_write_val", {16'h0, mem_write_val}, {16'h0, e.wdata});
            end
            held_addr = mem_addr;
            held_wren = mem_wren;
        end else if (mem_req) begin
            check("mem_addr_stable", {16'h0, mem_addr}, {16'h0, held_addr});
            check("mem_wren_stable", {31'h0, mem_wren}, {31'h0, held_wren});
        end
        prev_req = mem_req;
        if (core_ready != '0) begin
            check("ready_onehot", $countones(core_ready), 32'd1);
            if (exp_rdy.size() == 0) begin
                check("unexpected_ready", {28'h0, core_ready}, 32'd0);
            end else begin
                r = exp_rdy.pop_front();
                check("core_ready", {28'h0, core_ready}, {28'h0, r.ready});
                check("core_read_val", {16'h0, core_read_val}, {16'h0, r.rval});
            end
        end
    end

    int          remaining[N];
    logic [15:0] cur_addr[N];

    task automatic do_reset();
        reset = 1'b1;
        core_wren = '0;
        core_rden = '0;
        for (int i = 0; i < N; i++) remaining[i] = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic req(input int core, input bit wr, input logic [15:0] addr,
                       input logic [15:0] data, input int count);
        core_wren[core] = wr;
        core_rden[core] = !wr;
        core_addr[core*16 +: 16] = addr;
        core_write_val[core*16 +: 16] = data;
        cur_addr[core] = addr;
        remaining[core] = count;
    endtask

    // Runs until every core has its transactions; re-arms or drops on ready.
    task automatic run(input int budget, output int first_mem, output int first_rdy);
        int cyc = 0;
        bit busy = 1'b1;
        first_mem = -1;
        first_rdy = -1;
        while (busy && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (mem_req && first_mem < 0) first_mem = cyc;
            if (core_ready != '0 && first_rdy < 0) first_rdy = cyc;
            for (int i = 0; i < N; i++) begin
                if (core_ready[i] && remaining[i] > 0) begin
                    remaining[i]--;
                    if (remaining[i] > 0) begin
                        cur_addr[i] = cur_addr[i] + 16'd1;
                        core_addr[i*16 +: 16] = cur_addr[i];
                    end else begin
                        core_wren[i] = 1'b0;
                        core_rden[i] = 1'b0;
                    end
                end
            end
            busy = 1'b0;
            for (int i = 0; i < N; i++) if (remaining[i] > 0) busy = 1'b1;
        end
        check("run_timeout", {31'h0, busy}, 32'd0);
    endtask

    initial begin
        int fm, fr;
        reset = 1'b1;
        core_wren = '0; core_rden = '0; core_addr = '0; core_write_val = '0;
        @(negedge clk);
        check("rst_core_ready", {28'h0, core_ready}, 32'd0);
        check("rst_read_val", {16'h0, core_read_val}, 32'd0);
        check("rst_mem_req", {31'h0, mem_req}, 32'd0);
        check("rst_mem_wren", {31'h0, mem_wren}, 32'd0);
        check("rst_mem_addr", {16'h0, mem_addr}, 32'd0);
        check("rst_mem_wval", {16'h0, mem_write_val}, 32'd0);
        check("rst_stall", stall_count, 32'd0);
        do_reset();

        // 1: zero-wait read by core 0
        exp_mem.push_back('{addr: 16'h0100, wren: 1'b0, wdata: 16'h0000});
        exp_rdy.push_back('{ready: 4'b0001, rval: 16'h1234});
        req(0, 1'b0, 16'h0100, 16'h0000, 1);
        run(50, fm, fr);
        check("t1_mem_req_cycle", fm, 32'd1);
        check("t1_ready_cycle", fr, 32'd2);

        // spurious mem_ack while idle must be ignored
        spurious = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("spurious_no_req", {31'h0, mem_req}, 32'd0);
        end
        spurious = 1'b0;
        repeat (2) @(negedge clk);
        check("spurious_read_val", {16'h0, core_read_val}, 32'h1234);

        // 2: three simultaneous writes from reset, served 0,1,2
        do_reset();
        for (int i = 0; i < 3; i++) begin
            exp_mem.push_back('{addr: 16'h00A0 + 16'(i), wren: 1'b1, wdata: 16'h00A0 + 16'(i)});
            exp_rdy.push_back('{ready: 4'(1 << i), rval: 16'h0000});
        end
        for (int i = 0; i < 3; i++) req(i, 1'b1, 16'h00A0 + 16'(i), 16'h00A0 + 16'(i), 1);
        run(100, fm, fr);

        // 3: cores 1 and 3 continuously, 4 reads each, alternating 1,3
        do_reset();
        for (int t = 0; t < 4; t++) begin
            exp_mem.push_back('{addr: 16'h1100 + 16'(t), wren: 1'b0, wdata: 16'h0});
            exp_rdy.push_back('{ready: 4'b0010, rval: 16'h2234 + 16'(t)});
            exp_mem.push_back('{addr: 16'h3300 + 16'(t), wren: 1'b0, wdata: 16'h0});
            exp_rdy.push_back('{ready: 4'b1000, rval: 16'h4434 + 16'(t)});
        end
        req(1, 1'b0, 16'h1100, 16'h0, 4);
        req(3, 1'b0, 16'h3300, 16'h0, 4);
        run(200, fm, fr);

        // 4: four-cycle ack delay on a write by core 2
        do_reset();
        ack_delay = 4;
        exp_mem.push_back('{addr: 16'h0400, wren: 1'b1, wdata: 16'hBEEF});
        exp_rdy.push_back('{ready: 4'b0100, rval: 16'h0000});
        req(2, 1'b1, 16'h0400, 16'hBEEF, 1);
        run(50, fm, fr);
        check("t4_ready_cycle", fr, 32'd6);
        ack_delay = 0;

        // 5: reset during BUSY, then cores 2,3 -> core 2 first
        do_reset();
        ack_delay = 20;
        exp_mem.push_back('{addr: 16'h0500, wren: 1'b0, wdata: 16'h0});
        req(0, 1'b0, 16'h0500, 16'h0, 1);
        repeat (3) @(negedge clk);
        check("t5_busy_req", {31'h0, mem_req}, 32'd1);
        reset = 1'b1;
        #1;
        check("t5_reset_req", {31'h0, mem_req}, 32'd0);
        check("t5_reset_ready", {28'h0, core_ready}, 32'd0);
        core_wren = '0; core_rden = '0; remaining[0] = 0;
        @(negedge clk);
        reset = 1'b0;
        ack_delay = 0;
        exp_mem.push_back('{addr: 16'h2200, wren: 1'b0, wdata: 16'h0});
        exp_rdy.push_back('{ready: 4'b0100, rval: 16'h3334});
        exp_mem.push_back('{addr: 16'h3300, wren: 1'b0, wdata: 16'h0});
        exp_rdy.push_back('{ready: 4'b1000, rval: 16'h4434});
        req(2, 1'b0, 16'h2200, 16'h0, 1);
        req(3, 1'b0, 16'h3300, 16'h0, 1);
        run(100, fm, fr);

        // 6: stall counter with two competing single transactions
        do_reset();
        check("t6_stall_reset", stall_count, 32'd0);
        exp_mem.push_back('{addr: 16'h0600, wren: 1'b0, wdata: 16'h0});
        exp_rdy.push_back('{ready: 4'b0001, rval: 16'h1734});
        exp_mem.push_back('{addr: 16'h0601, wren: 1'b0, wdata: 16'h0});
        exp_rdy.push_back('{ready: 4'b0010, rval: 16'h1735});
        req(0, 1'b0, 16'h0600, 16'h0, 1);
        req(1, 1'b0, 16'h0601, 16'h0, 1);
        run(100, fm, fr);
        repeat (3) @(negedge clk);
        check("t6_stall_count", stall_count, 32'(EXP_STALL));

        check("exp_mem_drained", exp_mem.size(), 32'd0);
        check("exp_rdy_drained", exp_rdy.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
